ring_buffer_ctrl: RTL and testbench
===================================

RING_BUFFER_CTRL -- requirements
Module: ring_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous flush of the buffer.
REQ-006 The block SHALL have port wr_valid, input, 1 bit: a write is offered this cycle.
REQ-007 The block SHALL have port wr_data, input, DATA_W bits: the write word.
REQ-008 The block SHALL have port wr_ready, output, 1 bit: a write is accepted this cycle when wr_valid is also high.
REQ-009 The block SHALL have port rd_req, input, 1 bit: requests the oldest word.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: a one-cycle pulse marking rd_data valid.
REQ-011 The block SHALL have port rd_data, output, DATA_W bits: the read word.
REQ-012 The block SHALL have port count, output, ADDR_W+1 bits: the number of stored words, 0..DEPTH.
REQ-013 The block SHALL have ports full and empty, outputs, 1 bit each: full = (count==DEPTH), empty = (count==0).
REQ-014 The block SHALL have port overflow, output, 1 bit: a sticky write-when-full flag.

Function
REQ-015 The block SHALL keep storage as DEPTH x DATA_W; wr_ptr and rd_ptr SHALL be ADDR_W bits wide and wrap DEPTH-1 -> 0 naturally.
REQ-016 A write SHALL be accepted when wr_valid && wr_ready; mem[wr_ptr] <= wr_data and wr_ptr increments.
REQ-017 A read SHALL be accepted when rd_req && !empty; rd_ptr increments, and rd_data = the old mem[rd_ptr] SHALL appear with rd_valid high exactly 1 cycle later.
REQ-018 A rd_req while empty SHALL be ignored: no rd_valid, no pointer change.
REQ-019 An accepted read and an accepted write in the same cycle SHALL leave count unchanged; both pointers SHALL advance.
REQ-020 When empty, a simultaneous write and rd_req SHALL accept only the write; the read is rejected (there is no write-through).
REQ-021 rd_data SHALL hold its last value when rd_valid is low.
REQ-022 A clear SHALL set wr_ptr, rd_ptr, count and overflow to 0 on the next edge, SHALL take priority over same-cycle reads and writes, and SHALL suppress the rd_valid of a same-cycle read; a read accepted in the previous cycle SHALL still deliver its rd_valid.
REQ-023 overflow SHALL be set when wr_valid is high while full, and SHALL remain high until clear or reset.

Reset
REQ-024 On reset_n low the block SHALL asynchronously set wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_data=0 and overflow=0, giving empty=1, full=0 and wr_ready=1.
REQ-025 Memory contents SHALL NOT be reset.
REQ-026 A reset asserted mid-read SHALL cancel the pending rd_valid.

Configuration
REQ-027 Without RING_BUFFER_OVERWRITE_EN defined, the block SHALL drive wr_ready = !full, and a write attempted while full SHALL be dropped (overflow set).
REQ-028 With RING_BUFFER_OVERWRITE_EN defined, the block SHALL tie wr_ready to 1; a write while full SHALL overwrite the oldest word and advance rd_ptr, leaving count at DEPTH, and SHALL set overflow.
REQ-029 With RING_BUFFER_OVERWRITE_EN defined, a write while full together with a same-cycle accepted read SHALL advance rd_ptr by 1 only, with the read returning the word being displaced.

Structure
REQ-030 Package ring_buffer_pkg SHALL hold the default DATA_W and ADDR_W constants.
REQ-031 Storage SHALL be one sub-module, rb_dp_ram: a simple dual-port RAM with one write port and one registered read port (1-cycle latency), inferable as block RAM.
REQ-032 Pointer, count and flag logic SHALL reside in ring_buffer_ctrl.

Verification (DATA_W=8, ADDR_W=2, DEPTH=4)
REQ-033 The bench SHALL check: write 0x11,0x22,0x33 then three rd_req -> rd_data 0x11,0x22,0x33, each 1 cycle after its request; empty=1 at the end.
REQ-034 The bench SHALL check: write 0xA0..0xA3 -> full=1, count=4; in non-overwrite mode a further write of 0xFF -> wr_ready=0, overflow=1, and subsequent reads return 0xA0..0xA3.
REQ-035 The bench SHALL check, in overwrite mode: write 0xA0..0xA4 -> count=4, overflow=1, and reads return 0xA1..0xA4.
REQ-036 The bench SHALL check: with count=2, a simultaneous write and read -> count stays 2, and rd_data is the oldest word.
REQ-037 The bench SHALL check: rd_req while empty -> no rd_valid; then write 6 and read 6 words, crossing pointer wrap -> all data in order.
REQ-038 The bench SHALL check: reset_n pulsed low between an accepted rd_req and its rd_valid -> no rd_valid, count=0, overflow=0; likewise clear with count=3 -> empty=1 on the next cycle.

Source files
------------

// File: rtl/ring_buffer_pkg.sv
// Shared defaults for the ring buffer: data width and address width (depth = 2**addr_w).
// No logic, so no latency or backpressure of its own.
// Users either take these defaults or override them per instance.
package ring_buffer_pkg;
    localparam int RB_DATA_W = 8;
    localparam int RB_ADDR_W = 5;
endpackage

// File: rtl/rb_dp_ram.sv
// Simple dual-port RAM: one write port plus one read port, read-first on address collision.
// Read latency is 1 cycle, and the read register only loads when rd_en is high.
// No backpressure; the controller decides when each port fires.
module rb_dp_ram
    import ring_buffer_pkg::*;
#(
    parameter int DATA_W = RB_DATA_W,
    parameter int ADDR_W = RB_ADDR_W
) (
    input  logic              core_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_dat_q;

    // No reset here, so the memory can map onto block RAM.
    // A read that hits the address being written returns the old word.
    always_ff @(posedge core_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem_q[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/ring_buffer_ctrl.sv
// Ring buffer controller: pointers, count and flags around rb_dp_ram. RING_BUFFER_OVERWRITE_EN lets a write to a full buffer replace the oldest word.
// rd_data is valid 1 cycle after an accepted rd_req. Writes take effect on the next edge.
// wr_ready = !full by default. It is tied high when RING_BUFFER_OVERWRITE_EN is defined.
module ring_buffer_ctrl
    import ring_buffer_pkg::*;
#(
    parameter int DATA_W = RB_DATA_W,
    parameter int ADDR_W = RB_ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_hold_q, rd_hold_d;
    logic [DATA_W-1:0] ram_rd_dat;
    logic              wr_acc, rd_acc, displace, cnt_inc;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

`ifdef RING_BUFFER_OVERWRITE_EN
    assign wr_ready = 1'b1;
    // A write to a full buffer with no read this cycle pushes the oldest word out.
    assign displace = wr_acc && full && !rd_acc;
`else
    assign wr_ready = !full;
    assign displace = 1'b0;
`endif

    assign wr_acc  = wr_valid && wr_ready;
    assign rd_acc  = rd_req && !empty;
    assign cnt_inc = wr_acc && !displace;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (wr_valid && full);
        rd_valid_d = rd_acc && !clear;
        rd_hold_d  = rd_valid_q ? ram_rd_dat : rd_hold_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc || displace) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            if (cnt_inc && !rd_acc) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end else if (rd_acc && !cnt_inc) begin
                count_d = count_q - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    rb_dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .core_clk (CLOCK_50),
        .wr_en    (wr_acc && !clear),
        .wr_addr  (wr_ptr_q),
        .wr_dat   (wr_data),
        .rd_en    (rd_acc && !clear),
        .rd_addr  (rd_ptr_q),
        .rd_dat   (ram_rd_dat)
    );

    // Outside a read pulse, rd_data shows the last delivered word.
    // After reset it shows 0.
    assign rd_data  = rd_valid_q ? ram_rd_dat : rd_hold_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// Bench for ring_buffer_ctrl (DATA_W=8, ADDR_W=2): a table of per-cycle vectors with hand-written count and overflow.
// Read data is checked against a reference queue through a scoreboard.
module tb_ring_buffer_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
`ifdef RING_BUFFER_OVERWRITE_EN
    localparam bit OW = 1'b1;
`else
    localparam bit OW = 1'b0;
`endif

    typedef struct {
        logic          clr;
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        int            cnt;
        logic          ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic          wr_ready, rd_valid, full, empty, overflow;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;

    int            n_chk = 0;
    int            n_err = 0;
    logic [DW-1:0] model[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] last_rd = '0;
    vec_t          vecs[$];

    always #5 clk = ~clk;

    ring_buffer_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic wv, input logic [DW-1:0] wd,
                                input logic rr, input int cnt, input logic ovf);
        vec_t v;
        v.clr = clr; v.wv = wv; v.wd = wd; v.rr = rr; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    task automatic add(input logic clr, input logic wv, input logic [DW-1:0] wd,
                       input logic rr, input int cnt, input logic ovf);
        vecs.push_back(mk(clr, wv, wd, rr, cnt, ovf));
    endtask

    // Called at posedge+1: drive, update reference model, clock, then check outputs.
    task automatic apply(input vec_t v);
        logic          m_full, m_empty, rd_ok, wr_ok, exp_rv;
        logic [DW-1:0] e;
        clear    = v.clr;
        wr_valid = v.wv;
        wr_data  = v.wd;
        rd_req   = v.rr;
        m_full  = (model.size() == DEPTH);
        m_empty = (model.size() == 0);
        rd_ok   = v.rr && !m_empty;
        wr_ok   = v.wv && (OW || !m_full);
        exp_rv  = rd_ok && !v.clr;
        if (v.clr) begin
            model.delete();
        end else begin
            if (rd_ok) sb.push_back(model.pop_front());
            if (wr_ok) begin
                if (m_full && !rd_ok) void'(model.pop_front());
                model.push_back(v.wd);
            end
        end
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
        if (exp_rv) begin
            e = sb.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e));
            last_rd = e;
        end else begin
            chk("rd_data_hold", 32'(rd_data), 32'(last_rd));
        end
        chk("count", 32'(count), 32'(v.cnt));
        chk("full", 32'(full), 32'(v.cnt == DEPTH));
        chk("empty", 32'(empty), 32'(v.cnt == 0));
        chk("overflow", 32'(overflow), 32'(v.ovf));
        chk("wr_ready", 32'(wr_ready), 32'(OW ? 1'b1 : (v.cnt != DEPTH)));
    endtask

    initial begin
        // Three writes, three reads.
        add(0,1,8'h11,0, 1,0); add(0,1,8'h22,0, 2,0); add(0,1,8'h33,0, 3,0);
        add(0,0,8'h00,1, 2,0); add(0,0,8'h00,1, 1,0); add(0,0,8'h00,1, 0,0);
        add(0,0,8'h00,0, 0,0);
        // Read while empty, then 6 words across the pointer wrap, including write+read at count 2.
        add(0,0,8'h00,1, 0,0);
        add(0,1,8'h44,0, 1,0); add(0,1,8'h55,0, 2,0); add(0,1,8'h66,1, 2,0);
        add(0,1,8'h77,0, 3,0); add(0,0,8'h00,1, 2,0); add(0,1,8'h88,0, 3,0);
        add(0,1,8'h99,0, 4,0); add(0,0,8'h00,1, 3,0); add(0,0,8'h00,1, 2,0);
        add(0,0,8'h00,1, 1,0); add(0,0,8'h00,1, 0,0);
        // Write and read together while empty: only the write is taken.
        add(0,1,8'h5A,1, 1,0); add(0,0,8'h00,1, 0,0);
        // Fill, then write while full.
        add(0,1,8'hA0,0, 1,0); add(0,1,8'hA1,0, 2,0); add(0,1,8'hA2,0, 3,0);
        add(0,1,8'hA3,0, 4,0);
`ifdef RING_BUFFER_OVERWRITE_EN
        add(0,1,8'hA4,0, 4,1);
        add(0,1,8'hBB,1, 4,1);
        add(0,0,8'h00,1, 3,1); add(0,0,8'h00,1, 2,1); add(0,0,8'h00,1, 1,1);
        add(0,0,8'h00,1, 0,1);
`else
        add(0,1,8'hFF,0, 4,1);
        add(0,1,8'hBB,1, 3,1);
        add(0,0,8'h00,1, 2,1); add(0,0,8'h00,1, 1,1); add(0,0,8'h00,1, 0,1);
`endif
        // Clear at count 3 with a same-cycle write and read.
        add(0,1,8'hC1,0, 1,1); add(0,1,8'hC2,0, 2,1); add(0,1,8'hC3,0, 3,1);
        add(1,1,8'hC4,1, 0,0); add(0,0,8'h00,0, 0,0);
        // A read, then a clear on the next cycle.
        add(0,1,8'hD5,0, 1,0); add(0,0,8'h00,1, 0,0); add(1,0,8'h00,0, 0,0);

        #23;
        reset_n = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // Reset between an accepted read and use of its data, with overflow set.
        apply(mk(0,1,8'hF0,0, 1,0)); apply(mk(0,1,8'hF1,0, 2,0));
        apply(mk(0,1,8'hF2,0, 3,0)); apply(mk(0,1,8'hF3,0, 4,0));
        apply(mk(0,1,8'hF4,0, 4,1));
        clear    = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        @(posedge clk);
        #1;
        rd_req  = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
        model.delete();
        sb.delete();
        last_rd = '0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        apply(mk(0,1,8'h3C,0, 1,0));
        apply(mk(0,0,8'h00,1, 0,0));
        apply(mk(0,0,8'h00,0, 0,0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
